// File: rtl/sync_nt_fifo_pkg.sv
// Shared sizing helpers for the banked synchronous FIFO.
// Every function is a constant function, so it can size ports and parameters at elaboration.
package sync_nt_fifo_pkg;

   function automatic int calc_count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int calc_bank_depth(input int depth, input int banks);
      return depth / banks;
   endfunction

   // A single-entry bank or a single bank still needs a 1-bit index signal
   function automatic int calc_index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_nt_fifo_bank.sv
// One interleaved storage bank: a register array with its own write and read pointers.
// rdata always presents the word at the read pointer, which gives first-word-fall-through.
module sync_nt_fifo_bank
   import sync_nt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BANK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int PTR_W = calc_index_width(BANK_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BANK_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   // Clear rewinds only the pointers; the stale words behind them are never observable
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < BANK_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (we) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (re) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sync_nt_fifo.sv
// Synchronous FIFO with NUM_BANKS round-robin interleaved banks, valid/ready ports and occupancy flags.
// Define SYNC_NT_FIFO_HWM_EN to add the max_count high-water-mark output.
module sync_nt_fifo
   import sync_nt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_BANKS  = 2,
   parameter int AFULL_TH   = FIFO_DEPTH - 1,
   parameter int AEMPTY_TH  = 1
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic [DATA_WIDTH-1:0]                     in_data,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   output logic [DATA_WIDTH-1:0]                     out_data,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   input  logic                                      clear,
   output logic [calc_count_width(FIFO_DEPTH)-1:0]   count,
`ifdef SYNC_NT_FIFO_HWM_EN
   output logic [calc_count_width(FIFO_DEPTH)-1:0]   max_count,
`endif
   output logic                                      almost_full,
   output logic                                      almost_empty
);

   localparam int CNT_W      = calc_count_width(FIFO_DEPTH);
   localparam int BANK_DEPTH = calc_bank_depth(FIFO_DEPTH, NUM_BANKS);
   localparam int SEL_W      = calc_index_width(NUM_BANKS);

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(AEMPTY_TH);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_BANKS - 1);

   if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
      $error("sync_nt_fifo: FIFO_DEPTH must be a power of 2");
   end
   if (!is_pow2(NUM_BANKS)) begin : g_bad_banks
      $error("sync_nt_fifo: NUM_BANKS must be a power of 2");
   end
   if (FIFO_DEPTH < NUM_BANKS) begin : g_bad_ratio
      $error("sync_nt_fifo: FIFO_DEPTH must be at least NUM_BANKS");
   end

   logic                  push;
   logic                  pop;
   logic [SEL_W-1:0]      wr_sel;
   logic [SEL_W-1:0]      rd_sel;
   logic [CNT_W-1:0]      next_count;
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

   assign in_ready     = (count != CNT_FULL);
   assign out_valid    = (count != '0);
   assign push         = in_valid && in_ready;
   assign pop          = out_valid && out_ready;
   assign almost_full  = (count >= CNT_AFULL);
   assign almost_empty = (count <= CNT_AEMPT);
   assign out_data     = bank_rdata[rd_sel];

   always_comb begin
      next_count = count;
      case ({push, pop})
         2'b10:   next_count = count + 1'b1;
         2'b01:   next_count = count - 1'b1;
         default: next_count = count;
      endcase
   end

   // Bank selects rotate independently, so global order is the interleave of per-bank order
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         wr_sel <= '0;
         rd_sel <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_sel <= (wr_sel == SEL_LAST) ? '0 : wr_sel + 1'b1;
         end
         if (pop) begin
            rd_sel <= (rd_sel == SEL_LAST) ? '0 : rd_sel + 1'b1;
         end
         count <= next_count;
      end
   end

`ifdef SYNC_NT_FIFO_HWM_EN
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         max_count <= '0;
      end else if (next_count > max_count) begin
         max_count <= next_count;
      end
   end
`endif

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sync_nt_fifo_bank #(
         .DATA_WIDTH(DATA_WIDTH),
         .BANK_DEPTH(BANK_DEPTH)
      ) u_bank (
         .clk   (clk),
         .rstn  (rstn),
         .clear (clear),
         .we    (push && (wr_sel == SEL_W'(b))),
         .wdata (in_data),
         .re    (pop && (rd_sel == SEL_W'(b))),
         .rdata (bank_rdata[b])
      );
   end

endmodule
